// File: rtl/screen_scanner.sv
// screen_scanner: streams a 1bpp screen (ROWS x COLS 16-bit words) from screen memory as a
// ready/valid pixel stream. Define SCREEN_SCANNER_HBLANK_EN for a 16-cycle blank after each row.
module screen_scanner #(
  parameter int ROWS = 256,
  parameter int COLS = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  output logic [12:0] mem_address,
  input  logic [15:0] mem_data,
  output logic        pixel,
  output logic        pixel_valid,
  input  logic        pixel_ready,
  output logic        sof,
  output logic        eol,
  output logic        frame_done
);
  localparam logic [7:0] LAST_ROW = 8'(ROWS - 1);
  localparam logic [4:0] LAST_COL = 5'(COLS - 1);

`ifdef SCREEN_SCANNER_HBLANK_EN
  typedef enum logic [2:0] {IDLE, FETCH, SHIFT, DONE, HBLANK} state_t;
`else
  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;
`endif

  state_t      state, state_nxt;
  logic [7:0]  row;
  logic [4:0]  col;
  logic [3:0]  bcnt;
  logic [15:0] shreg;
  logic        xfer, last_bit, last_col, last_row;
`ifdef SCREEN_SCANNER_HBLANK_EN
  logic [3:0]  hcnt;
`endif

  assign xfer     = (state == SHIFT) && pixel_ready;
  assign last_bit = (bcnt == 4'd15);
  assign last_col = (col == LAST_COL);
  assign last_row = (row == LAST_ROW);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (enable) state_nxt = FETCH;
      FETCH: state_nxt = SHIFT;
      SHIFT: if (xfer && last_bit) begin
        if (!last_col)      state_nxt = FETCH;
`ifdef SCREEN_SCANNER_HBLANK_EN
        else                state_nxt = HBLANK;
`else
        else if (!last_row) state_nxt = FETCH;
        else                state_nxt = DONE;
`endif
      end
`ifdef SCREEN_SCANNER_HBLANK_EN
      HBLANK: if (hcnt == 4'd15) state_nxt = last_row ? DONE : FETCH;
`endif
      DONE:  state_nxt = enable ? FETCH : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Row/col only ever return to zero via the end-of-frame path, never by overflow.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row   <= '0;
      col   <= '0;
      bcnt  <= '0;
      shreg <= '0;
`ifdef SCREEN_SCANNER_HBLANK_EN
      hcnt  <= '0;
`endif
    end else begin
      case (state)
        FETCH: begin
          shreg <= mem_data;
          bcnt  <= '0;
        end
        SHIFT: if (xfer) begin
          shreg <= {1'b0, shreg[15:1]};
          bcnt  <= bcnt + 4'd1;
          if (last_bit) begin
            if (!last_col) col <= col + 5'd1;
`ifndef SCREEN_SCANNER_HBLANK_EN
            else begin
              col <= '0;
              row <= last_row ? 8'd0 : row + 8'd1;
            end
`endif
          end
        end
`ifdef SCREEN_SCANNER_HBLANK_EN
        // Address stays on the row's last word for the whole blank.
        HBLANK: begin
          hcnt <= hcnt + 4'd1;
          if (hcnt == 4'd15) begin
            col <= '0;
            row <= last_row ? 8'd0 : row + 8'd1;
          end
        end
`endif
        DONE: begin
          row <= '0;
          col <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    pixel_valid = (state == SHIFT);
    pixel       = pixel_valid & shreg[0];
    sof         = pixel_valid && (row == 8'd0) && (col == 5'd0) && (bcnt == 4'd0);
    eol         = pixel_valid && last_col && last_bit;
    frame_done  = (state == DONE);
    mem_address = '0;
`ifdef SCREEN_SCANNER_HBLANK_EN
    if (state == FETCH || state == SHIFT || state == HBLANK) mem_address = {row, col};
`else
    if (state == FETCH || state == SHIFT) mem_address = {row, col};
`endif
  end
endmodule

// File: tb/tb_screen_scanner.sv
// Bench for screen_scanner on a reduced 40x8-word screen; pixel stream checked against a
// pixel-index model of the memory image (row-major, bit 0 first).
module tb_screen_scanner;
  localparam int ROWS  = 40;
  localparam int COLS  = 8;
  localparam int WORDS = ROWS * COLS;
  localparam int TOTAL = WORDS * 16;
`ifdef SCREEN_SCANNER_HBLANK_EN
  localparam int HB = 16;
`else
  localparam int HB = 0;
`endif
  localparam int LIMIT = 40000;

  logic        clock = 1'b0;
  logic        reset, enable, pixel_ready;
  logic [12:0] mem_address;
  logic [15:0] mem_data;
  logic        pixel, pixel_valid, sof, eol, frame_done;
  logic [15:0] mem [0:8191];

  int n_vec = 0;
  int n_err = 0;

  assign mem_data = mem[mem_address];

  always #5 clock = ~clock;

  screen_scanner #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .mem_address(mem_address), .mem_data(mem_data),
    .pixel(pixel), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
    .sof(sof), .eol(eol), .frame_done(frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] waddr(input int p);
    int w;
    w = p / 16;
    return 13'(((w / COLS) << 5) | (w % COLS));
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_valid"}, 32'(pixel_valid), 0);
    chk({tag, "_pixel"}, 32'(pixel), 0);
    chk({tag, "_sof"},   32'(sof), 0);
    chk({tag, "_eol"},   32'(eol), 0);
    chk({tag, "_done"},  32'(frame_done), 0);
    chk({tag, "_addr"},  32'(mem_address), 0);
  endtask

  // mode 0: ready always 1; mode 1: ready pattern 1,0,0,1; mode 2: random ready.
  // Drops enable once drop_p pixels are through; returns early at pixel stop_p.
  task automatic run_frame(input int mode, input int drop_p, input int stop_p);
    int  p, cyc, first;
    bit  rdy, done;
    logic [12:0] a;
    p = 0; cyc = 0; first = -1; done = 0;
    while (!done && cyc < LIMIT) begin
      @(negedge clock);
      cyc++;
      if (pixel_valid) begin
        if (first < 0) begin
          first = cyc;
          chk("first_valid_cycle", 32'(first), 2);
        end
        a = waddr(p);
        chk("addr",  32'(mem_address), 32'(a));
        chk("pixel", 32'(pixel), 32'(mem[a][p % 16]));
        chk("sof",   32'(sof), 32'(p == 0));
        chk("eol",   32'(eol), 32'((p % 16 == 15) && ((p / 16) % COLS == COLS - 1)));
      end else begin
        chk("gap_pixel", 32'(pixel), 0);
        chk("gap_eol",   32'(eol), 0);
      end
      if (frame_done) begin
        chk("done_count", 32'(p), 32'(TOTAL));
        chk("done_valid", 32'(pixel_valid), 0);
        if (mode == 0) chk("frame_len", 32'(cyc), 32'(first + WORDS * 17 - 1 + ROWS * HB));
        done = 1;
      end else if (stop_p >= 0 && p == stop_p && pixel_valid) begin
        done = 1;
      end else begin
        if (drop_p >= 0 && p >= drop_p) enable = 1'b0;
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
          default: rdy = ($urandom_range(0, 3) != 0);
        endcase
        pixel_ready = rdy;
        if (pixel_valid && rdy) p++;
      end
    end
    if (!done) chk("frame_timeout", 0, 1);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; pixel_ready = 1'b0;
    for (int a = 0; a < 8192; a++) mem[a] = 16'h0000;
    mem[0] = 16'h0005;
    #1 chk_quiet("in_reset");
    repeat (3) @(negedge clock);
    chk_quiet("in_reset_clk");
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk_quiet("idle");

    // Enable driven here, sampled at the next edge; first pixel two edges later.
    enable = 1'b1;
    pixel_ready = 1'b1;
    run_frame(0, -1, -1);

    // Enable held: back-to-back frame over an address-valued image with stalls,
    // enable dropped at row 20 so the block parks in IDLE afterwards.
    for (int a = 0; a < 8192; a++) mem[a] = 16'(a);
    run_frame(1, 20 * COLS * 16, -1);
    repeat (3) begin
      @(negedge clock);
      chk_quiet("post_drop_idle");
    end

    // Random image, random ready; asynchronous reset at row 37 col 5 bit 9.
    for (int a = 0; a < 8192; a++) mem[a] = 16'($urandom);
    enable = 1'b1;
    run_frame(2, -1, (37 * COLS + 5) * 16 + 9);
    chk("midframe_valid", 32'(pixel_valid), 1);
    #2 reset = 1'b1;
    enable = 1'b0;
    #1 chk_quiet("async_reset");
    repeat (2) @(negedge clock);
    chk_quiet("async_reset_hold");
    reset = 1'b0;
    @(negedge clock);
    chk_quiet("after_reset");

    enable = 1'b1;
    run_frame(2, 0, -1);
    repeat (2) begin
      @(negedge clock);
      chk_quiet("final_idle");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/screen_scanner.md
SCREEN_SCANNER -- requirements
Module: screen_scanner

Interface
REQ-001 SHALL have port clock  input  1  the single system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port enable  input  1  level request to scan frames.
REQ-004 SHALL have port mem_address  output  13  screen-memory word address, {row[7:0], col[4:0]}.
REQ-005 SHALL have port mem_data  input  16  word read from screen memory, valid combinationally in the same cycle mem_address is driven.
REQ-006 SHALL have port pixel  output  1  current pixel (1 = black).
REQ-007 SHALL have port pixel_valid  output  1  pixel is offered.
REQ-008 SHALL have port pixel_ready  input  1  consumer accepts the pixel.
REQ-009 SHALL have port sof  output  1  high with the first pixel of a frame (row 0, col 0, bit 0).
REQ-010 SHALL have port eol  output  1  high with the last pixel of a row (col 31, bit 15).
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse after a frame completes.

Function
REQ-012 SHALL scan 256 rows x 32 words x 16 bits = 131072 pixels per frame, row-major, word bit 0 first (leftmost pixel).
REQ-013 SHALL implement states IDLE, FETCH, SHIFT, DONE, plus HBLANK when REQ-025 applies.
REQ-014 IDLE: pixel_valid=0; mem_address=0; enable=1 at an edge -> FETCH.
REQ-015 FETCH: lasts exactly one cycle; mem_address={row,col}; mem_data captured into a 16-bit shift register at the edge ending FETCH; next state SHIFT with bit count 0.
REQ-016 SHIFT: pixel_valid=1, pixel=shift register bit 0; a transfer occurs on an edge where pixel_valid&pixel_ready=1.
REQ-017 Each transfer SHALL shift right by one and increment the 4-bit bit count; pixel, sof and eol SHALL stay stable while pixel_valid=1 and pixel_ready=0.
REQ-018 On the transfer of bit 15: col!=31 -> FETCH with col+1; col=31 and row!=255 -> FETCH with col=0, row+1 (or HBLANK per REQ-025); col=31 and row=255 -> DONE (or HBLANK per REQ-025).
REQ-019 DONE: lasts one cycle, frame_done=1, row and col cleared to 0; then FETCH if enable=1, else IDLE.
REQ-020 Deasserting enable mid-frame SHALL NOT abort the frame; it is sampled only in IDLE and DONE.
REQ-021 With pixel_ready held high, each word SHALL take exactly 17 cycles (1 FETCH + 16 SHIFT); the first pixel_valid SHALL appear 2 cycles after the edge sampling enable in IDLE.
REQ-022 Row and col counters SHALL wrap from 255/31 to 0 only through DONE, never by arithmetic overflow.

Reset
REQ-023 reset=1 SHALL immediately force state IDLE, row=0, col=0, bit count=0, shift register=0, regardless of the clock, including mid-frame.
REQ-024 While in reset and after reset: pixel_valid=0, pixel=0, sof=0, eol=0, frame_done=0, mem_address=0.

Configuration
REQ-025 With SCREEN_SCANNER_HBLANK_EN defined: after the bit-15 transfer at col=31, the block SHALL enter HBLANK for exactly 16 cycles with pixel_valid=0, mem_address held, then go to FETCH (row!=255, with row+1, col=0) or DONE (row=255).
REQ-026 Without SCREEN_SCANNER_HBLANK_EN: the HBLANK state and its counter SHALL not exist and the transitions of REQ-018 SHALL apply directly.

Verification
REQ-027 Reset, enable=1, ready=1, mem word 0 = 16'h0005 -> pixel_valid rises 2 cycles after enable edge; first pixels 1,0,1,0 then zeros; sof=1 only on first pixel.
REQ-028 ready=1, memory filled with address value -> mem_address sequence 0,1,...,8191; eol on every 512th pixel; frame_done pulses once after 131072 transfers (139264 cycles per frame +1 DONE, without macro).
REQ-029 ready toggled 1,0,0,1 in SHIFT -> pixel/sof/eol held during stall; no pixel lost or duplicated versus memory image.
REQ-030 enable dropped at row 100 -> frame completes, frame_done pulses, state returns to IDLE with pixel_valid=0; enable held -> next frame starts at address 0 with sof=1.
REQ-031 reset asserted mid-edge-free at row 37 col 5 bit 9 -> outputs zero immediately; after release and enable, scan restarts at address 0.
REQ-032 SCREEN_SCANNER_HBLANK_EN defined, ready=1 -> exactly 16 pixel_valid=0 cycles after each eol, frame length 139264+4096+1 cycles.
